// File: rtl/sc_bitstream_decoder_if.sv
// rtl/sc_bitstream_decoder_if.sv - control, bitstream and result signals of the stochastic decoder
interface sc_bitstream_decoder_if #(
  parameter int N = 8
);
  logic                start;
  logic                bit_in;
  logic                bit_valid;
  logic                busy;
  logic                done;
  logic [N:0]          count;
  logic signed [N+1:0] value;

  // Requester side: issues start and feeds the stochastic bitstream
  modport master (
    output start,
    output bit_in,
    output bit_valid,
    input  busy,
    input  done,
    input  count,
    input  value
  );

  // Decoder side: consumes the bitstream and returns the window result
  modport slave (
    input  start,
    input  bit_in,
    input  bit_valid,
    output busy,
    output done,
    output count,
    output value
  );
endinterface

// File: rtl/sc_bitstream_decoder.sv
// rtl/sc_bitstream_decoder.sv - counts ones over a 2**N sample window and decodes the bipolar value
module sc_bitstream_decoder #(
  parameter int N       = 8,
  parameter int BIPOLAR = 1
) (
  input logic                  clk,
  input logic                  reset,
  sc_bitstream_decoder_if.slave bus
);

  // Sample index of the final sample in a window; reaching it closes the window.
  localparam logic [N:0]   LAST_IDX = (N+1)'((1 << N) - 1);
  // Bipolar offset 2**N expressed in the value width.
  localparam logic [N+1:0] OFFSET   = (N+2)'(1 << N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [N:0]          sample_cnt;
  logic [N:0]          ones_acc;
  logic [N:0]          ones_next;
  logic [N+1:0]        decoded;

  // Accumulator value including the current sample, and its decoded form.
  always_comb begin
    ones_next = ones_acc + {{N{1'b0}}, bus.bit_in};
    if (BIPOLAR != 0) begin
      decoded = {ones_next, 1'b0} - OFFSET;
    end else begin
      decoded = {1'b0, ones_next};
    end
  end

  // Window FSM: counters, registered handshake flags and held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      sample_cnt <= '0;
      ones_acc   <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.count  <= '0;
      bus.value  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          sample_cnt <= '0;
          ones_acc   <= '0;
          bus.done   <= 1'b0;
          if (bus.start) begin
            state    <= S_ACCUM;
            bus.busy <= 1'b1;
          end
        end

        S_ACCUM: begin
          // start is deliberately not looked at here: a running window is never restarted.
          if (bus.bit_valid) begin
            sample_cnt <= sample_cnt + 1'b1;
            ones_acc   <= ones_next;
            if (sample_cnt == LAST_IDX) begin
              state     <= S_DONE;
              bus.busy  <= 1'b0;
              bus.done  <= 1'b1;
              bus.count <= ones_next;
              bus.value <= decoded;
            end
          end
        end

        S_DONE: begin
          // Counters clear here so a back-to-back start begins from zero.
          bus.done   <= 1'b0;
          sample_cnt <= '0;
          ones_acc   <= '0;
          if (bus.start) begin
            state    <= S_ACCUM;
            bus.busy <= 1'b1;
          end else begin
            state    <= S_IDLE;
          end
        end

        default: begin
          state      <= S_IDLE;
          sample_cnt <= '0;
          ones_acc   <= '0;
          bus.busy   <= 1'b0;
          bus.done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// tb/tb_sc_bitstream_decoder.sv - scoreboard bench for the stochastic bitstream decoder
module tb_sc_bitstream_decoder;

  localparam int N = 3;

  typedef struct {
    int cnt;
    int val;
    int cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  logic prev_done;
  exp_t sb_q[$];

  sc_bitstream_decoder_if #(.N(N)) bus ();

  sc_bitstream_decoder #(.N(N), .BIPOLAR(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done === 1'b1) begin
        exp_t e;
        chk("done_not_consecutive", prev_done, 0);
        chk("busy_low_in_done", bus.busy, 0);
        if (sb_q.size() == 0) begin
          chk("unexpected_done", bus.done, 0);
        end else begin
          e = sb_q.pop_front();
          chk("count", bus.count, e.cnt);
          chk("value", bus.value, e.val);
          chk("done_latency", cyc, e.cyc);
        end
      end
      prev_done = bus.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  function automatic int ones8(input logic [7:0] p);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(p[i]);
    return c;
  endfunction

  // Drives one window. Bits and valid are asserted during the start cycle to show they are ignored.
  task automatic run_window(input logic [7:0] pat, input int gap_at, input int gap_len,
                            input int mid_start_at, input int hold_cnt);
    exp_t e;
    int   c;
    c = ones8(pat);
    bus.start     = 1'b1;
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    e.cnt = c;
    e.val = 2 * c - 8;
    e.cyc = cyc + 9 + ((gap_at >= 0) ? gap_len : 0);
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    for (int i = 0; i < 8; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          bus.bit_valid = 1'b0;
          bus.bit_in    = 1'b1;
          @(negedge clk);
        end
      end
      bus.start     = (i == mid_start_at);
      bus.bit_valid = 1'b1;
      bus.bit_in    = pat[7-i];
      if (i == 3 && hold_cnt >= 0) begin
        chk("held_count", bus.count, hold_cnt);
        chk("held_value", bus.value, 2 * hold_cnt - 8);
      end
      @(negedge clk);
    end
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc           = 0;
    checks        = 0;
    errors        = 0;
    prev_done     = 1'b0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_count", bus.count, 0);
    chk("reset_value", bus.value, 0);
    reset = 1'b0;
    idle(2);

    run_window(8'b1111_1111, -1, 0, -1, -1);
    idle(2);
    run_window(8'b0000_0000, -1, 0, -1, -1);
    idle(2);
    run_window(8'b1010_1010, -1, 0, -1, -1);
    idle(2);
    run_window(8'b1101_1101, 4, 3, -1, -1);
    idle(2);

    // Back-to-back: second start lands in the DONE cycle of the first window.
    run_window(8'b1111_1111, -1, 0, -1, -1);
    run_window(8'b1100_0000, -1, 0, -1, 8);
    idle(2);

    run_window(8'b1110_0000, -1, 0, 4, -1);
    idle(3);

    // Abort a window with reset after five samples; no result may appear.
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = 1'b1;
      @(negedge clk);
    end
    bus.bit_valid = 1'b0;
    reset         = 1'b1;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_count", bus.count, 0);
    chk("abort_value", bus.value, 0);
    reset = 1'b0;
    idle(12);
    chk("abort_no_done_count", bus.count, 0);
    run_window(8'b1111_1111, -1, 0, -1, -1);
    idle(2);

    for (int t = 0; t < 40 && sb_q.size() != 0; t++) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
